// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and helpers for the display path
package display_pkg;

    localparam int DISPLAY_DATA_W = 8;

    // Index width that never collapses to zero, so a 1-client build still has a port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
module rr_pick
    import display_pkg::*;
#(
    parameter int N = 4,
    localparam int PTR_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    logic [2*N-1:0] req2;
    logic [2*N-1:0] masked;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search over bits at or above ptr.
    always_comb begin
        req2         = {req, req};
        masked       = '0;
        grant_idx    = '0;
        grant_onehot = '0;
        any          = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            masked[j] = req2[j] && (j >= int'(ptr));
        end
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (masked[j]) begin
                any       = 1'b1;
                grant_idx = PTR_W'((j >= N) ? (j - N) : j);
            end
        end
        for (int i = 0; i < N; i++) begin
            grant_onehot[i] = any && (grant_idx == PTR_W'(i));
        end
    end

endmodule

// File: rtl/rr_display_arbiter.sv
// rtl/rr_display_arbiter.sv - round-robin merge of client channels into the display register
module rr_display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = DISPLAY_DATA_W,
    localparam int SRC_W      = clog2_min1(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
    input  logic [NUM_CLIENTS-1:0]        client_valid,
    output logic [NUM_CLIENTS-1:0]        client_ready,
    input  logic [NUM_CLIENTS-1:0]        client_en,
    output logic                          disp_valid,
    input  logic                          disp_ready,
    output logic [DATA_W-1:0]             disp_data,
    output logic [SRC_W-1:0]              disp_src
);

    logic [SRC_W-1:0]       ptr_q, ptr_d;
    logic                   disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]      disp_data_q, disp_data_d;
    logic [SRC_W-1:0]       disp_src_q, disp_src_d;

    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] grant_onehot;
    logic [SRC_W-1:0]       grant_idx;
    logic                   any;
    logic                   load;

    assign req = client_valid & client_en;

    rr_pick #(
        .N (NUM_CLIENTS)
    ) u_pick (
        .req          (req),
        .ptr          (ptr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    always_comb begin
        load         = !disp_valid_q || disp_ready;
        ptr_d        = ptr_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        disp_src_d   = disp_src_q;
        // rst gates the handshake so no client sees a consume while the register is cleared.
        client_ready = (load && any && !rst) ? grant_onehot : '0;
        if (load) begin
            disp_valid_d = any;
            if (any) begin
                disp_data_d = client_data[int'(grant_idx)*DATA_W +: DATA_W];
                disp_src_d  = grant_idx;
                ptr_d       = (int'(grant_idx) == NUM_CLIENTS - 1) ? '0 : grant_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_src_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            disp_src_q   <= disp_src_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign disp_src   = disp_src_q;

endmodule

// File: tb/tb_rr_display_arbiter.sv
// tb/tb_rr_display_arbiter.sv - self-checking bench for rr_display_arbiter
module tb_rr_display_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] cd;
    logic [N-1:0]   cv, ce, cr;
    logic           dr, dv;
    logic [W-1:0]   dd;
    logic [1:0]     ds;

    logic [3*W-1:0] cd3 = 24'h332211;
    logic [2:0]     cv3 = 3'b111;
    logic [2:0]     ce3 = 3'b111;
    logic [2:0]     cr3;
    logic           dr3 = 1'b1;
    logic           dv3;
    logic [W-1:0]   dd3;
    logic [1:0]     ds3;

    always #5 clk = ~clk;

    rr_display_arbiter #(.NUM_CLIENTS(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .client_data(cd), .client_valid(cv), .client_ready(cr),
        .client_en(ce), .disp_valid(dv), .disp_ready(dr), .disp_data(dd), .disp_src(ds)
    );

    rr_display_arbiter #(.NUM_CLIENTS(3), .DATA_W(W)) dut3 (
        .clk(clk), .rst(rst), .client_data(cd3), .client_valid(cv3), .client_ready(cr3),
        .client_en(ce3), .disp_valid(dv3), .disp_ready(dr3), .disp_data(dd3), .disp_src(ds3)
    );

    int n_cmp = 0;
    int n_fail = 0;

    int           m_ptr, m_src, g;
    logic         m_valid, found, m_load;
    logic [W-1:0] m_data;
    logic [N-1:0] exp_ready;

    int           sb_src[$];
    logic [W-1:0] sb_data[$];
    int           waitc[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input int i);
        return cd[i*W +: W];
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_src = 0; m_valid = 1'b0; m_data = '0;
        sb_src.delete(); sb_data.delete();
        for (int i = 0; i < N; i++) waitc[i] = 0;
    endtask

    // Reference: walk clients starting at the pointer, first requester wins.
    task automatic model_comb();
        found = 1'b0; g = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!found && cv[idx] && ce[idx]) begin
                found = 1'b1; g = idx;
            end
        end
        m_load = !m_valid || dr;
        exp_ready = (m_load && found) ? (N'(1) << g) : '0;
    endtask

    task automatic model_update();
        if (m_load) begin
            m_valid = found;
            if (found) begin
                m_data = word(g); m_src = g; m_ptr = (g + 1) % N;
            end
        end
    endtask

    // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
    task automatic do_cycle();
        bit any_hs;
        model_comb();
        #2;
        chk("client_ready", 32'(cr), 32'(exp_ready));
        if (dv && dr) begin
            if (sb_src.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("sb_src", 32'(ds), 32'(sb_src.pop_front()));
                chk("sb_data", 32'(dd), 32'(sb_data.pop_front()));
            end
        end
        any_hs = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cr[i] && cv[i]) begin
                sb_src.push_back(i); sb_data.push_back(word(i)); any_hs = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!(cv[i] && ce[i]) || cr[i]) waitc[i] = 0;
            else if (any_hs) waitc[i]++;
            chk("fairness", 32'(waitc[i] < N), 1);
        end
        @(posedge clk);
        model_update();
        #1;
        chk("disp_valid", 32'(dv), 32'(m_valid));
        chk("disp_data", 32'(dd), 32'(m_data));
        chk("disp_src", 32'(ds), 32'(m_src));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cd = 32'h44332211; cv = '1; ce = '1; dr = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dv), 0);
        chk("rst_data", 32'(dd), 0);
        chk("rst_src", 32'(ds), 0);
        chk("rst_ready", 32'(cr), 0);
        chk("rst_valid3", 32'(dv3), 0);
        rst = 1'b0;

        // All four valid: 11,22,33,44,11,...; the 3-client instance wraps at 3.
        for (int k = 0; k < 6; k++) begin
            do_cycle();
            chk("seq4_src", 32'(ds), 32'(k % 4));
            chk("seq4_data", 32'(dd), 32'(8'h11 * (k % 4 + 1)));
            chk("seq3_src", 32'(ds3), 32'(k % 3));
            chk("seq3_data", 32'(dd3), 32'(8'h11 * (k % 3 + 1)));
        end

        cv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            chk("alt_valid", 32'(dv), 1);
        end
        ce = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("en_src", 32'(ds), 1);
        end

        ce = '1; cv = '1;
        reset_dut();
        do_cycle();
        do_cycle();
        chk("pre_stall", 32'(dd), 32'h22);
        dr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            do_cycle();
            chk("stall_data", 32'(dd), 32'h22);
            chk("stall_valid", 32'(dv), 1);
        end
        dr = 1'b1;
        do_cycle();
        chk("after_stall_src", 32'(ds), 2);

        dr = 1'b0;
        do_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(dv), 0);
        chk("async_data", 32'(dd), 0);
        chk("async_ready", 32'(cr), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dr = 1'b1;
        do_cycle();
        chk("post_rst_src", 32'(ds), 0);

        for (int k = 0; k < 10000; k++) begin
            cd = $urandom;
            cv = N'($urandom);
            for (int i = 0; i < N; i++) ce[i] = ($urandom_range(0, 7) != 0);
            dr = ($urandom_range(0, 3) != 0);
            do_cycle();
        end
        chk("sb_leftover", 32'(sb_src.size()), 32'(dv));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
